// File: rtl/sdq_arb_pkg.sv
// Shared types and helpers for the SRAM port arbiter.
package sdq_arb_pkg;

  // Read in flight between grant and response capture.
  typedef struct packed {
    logic       valid;
    logic [7:0] id;
    logic       err;
  } rd_tag_t;

  function automatic logic is_in_range(input logic [31:0] addr, input logic [31:0] depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/sdq_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, pointer moves past the winner on advance.
module sdq_rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] elig,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] gidx;
  logic [PW-1:0] idx;
  logic          found;

  // Scan from ptr upward (wrapping); the first eligible requester wins.
  always_comb begin
    grant = '0;
    gidx  = ptr;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (!found && elig[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        gidx        = idx;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      ptr <= '0;
    else if (advance)
      ptr <= (gidx == PW'(N - 1)) ? '0 : gidx + 1'b1;
  end

endmodule

// File: rtl/sdq_port_arbiter.sv
// Shares one single-port SRAM macro between NUM_REQ requesters with round-robin grant
// and a one-deep read response slot per requester.
module sdq_port_arbiter
  import sdq_arb_pkg::*;
#(
  parameter int BITS       = 64,
  parameter int WORD_DEPTH = 17,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REQ    = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*BITS-1:0]       req_wd,
  output logic [NUM_REQ-1:0]            rsp_valid,
  input  logic [NUM_REQ-1:0]            rsp_ready,
  output logic [NUM_REQ*BITS-1:0]       rsp_data,
  output logic [NUM_REQ-1:0]            rsp_err,
  output logic                          sram_ce,
  output logic                          sram_we,
  output logic [ADDR_WIDTH-1:0]         sram_addr,
  output logic [BITS-1:0]               sram_wd,
  input  logic [BITS-1:0]               sram_rd
);

  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] addr_a;
  logic [NUM_REQ-1:0][BITS-1:0]       wd_a;
  logic [NUM_REQ-1:0][BITS-1:0]       slot_data;
  logic [NUM_REQ-1:0]                 slot_vld, slot_err;
  logic [NUM_REQ-1:0]                 elig, grant, pop, inflight;

  rd_tag_t               tag;
  logic                  gnt_any, sel_we, in_rng;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [BITS-1:0]       sel_wd;
  logic [7:0]            gnt_id;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    assign addr_a[i]   = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign wd_a[i]     = req_wd[i*BITS +: BITS];
    assign inflight[i] = tag.valid && (tag.id == 8'(i));
    assign pop[i]      = slot_vld[i] & rsp_ready[i];
    // A read needs a free landing slot by the time its data returns.
    assign elig[i]     = !reset && req_valid[i] &&
                         (req_we[i] || (!inflight[i] && (!slot_vld[i] || pop[i])));

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        slot_vld[i]  <= 1'b0;
        slot_err[i]  <= 1'b0;
        slot_data[i] <= '0;
      end else if (inflight[i]) begin
        slot_vld[i]  <= 1'b1;
        slot_err[i]  <= tag.err;
        slot_data[i] <= tag.err ? '0 : sram_rd;
      end else if (pop[i]) begin
        slot_vld[i]  <= 1'b0;
      end
    end

    assign rsp_data[i*BITS +: BITS] = slot_data[i];
  end

  assign rsp_valid = slot_vld;
  assign rsp_err   = slot_err;

  sdq_rr_arbiter #(.N(NUM_REQ)) u_rr (
    .clk     (clk),
    .reset   (reset),
    .elig    (elig),
    .advance (gnt_any),
    .grant   (grant)
  );

  assign req_ready = grant;
  assign gnt_any   = |grant;

  always_comb begin
    sel_we   = 1'b0;
    sel_addr = '0;
    sel_wd   = '0;
    gnt_id   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_we   = req_we[i];
        sel_addr = addr_a[i];
        sel_wd   = wd_a[i];
        gnt_id   = 8'(i);
      end
    end
  end

  // Out-of-range accesses are granted but never reach the macro.
  assign in_rng    = is_in_range(32'(sel_addr), 32'(WORD_DEPTH));
  assign sram_ce   = gnt_any && in_rng;
  assign sram_we   = gnt_any && sel_we && in_rng;
  assign sram_addr = sel_addr;
  assign sram_wd   = sel_wd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag <= '0;
    end else begin
      tag.valid <= gnt_any && !sel_we;
      tag.id    <= gnt_id;
      tag.err   <= !in_rng;
    end
  end

endmodule

// File: tb/tb_sdq_port_arbiter.sv
// Directed bench for sdq_port_arbiter with a behavioural 1-cycle-read SRAM macro.
module tb_sdq_port_arbiter;

  localparam int BITS = 64, WD = 17, AW = 5, NR = 2;

  logic              clk = 1'b0, reset;
  logic [NR-1:0]     req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*BITS-1:0] req_wd, rsp_data;
  logic              sram_ce, sram_we;
  logic [AW-1:0]     sram_addr;
  logic [BITS-1:0]   sram_wd, sram_rd;
  logic [BITS-1:0]   mem [0:31];

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  sdq_port_arbiter #(.BITS(BITS), .WORD_DEPTH(WD), .ADDR_WIDTH(AW), .NUM_REQ(NR)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wd(req_wd),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .sram_ce(sram_ce), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wd(sram_wd),
    .sram_rd(sram_rd)
  );

  always @(posedge clk) begin
    if (sram_ce) begin
      if (sram_we) mem[sram_addr] <= sram_wd;
      else         sram_rd <= mem[sram_addr];
    end
  end

  typedef struct {
    logic [1:0]  v, we, rr;
    logic [4:0]  a0, a1;
    logic [63:0] wd0;
    logic [1:0]  rdy;
    logic        ce, swe;
    logic [4:0]  saddr;
    logic [63:0] ewd;
    logic [1:0]  rv, re;
    logic [63:0] rd0, rd1;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [1:0] v, logic [1:0] we, logic [1:0] rr, logic [4:0] a0,
                              logic [4:0] a1, logic [63:0] wd0, logic [1:0] rdy, logic ce,
                              logic swe, logic [4:0] saddr, logic [63:0] ewd, logic [1:0] rv,
                              logic [1:0] re, logic [63:0] rd0, logic [63:0] rd1);
    vec_t t;
    t.v = v; t.we = we; t.rr = rr; t.a0 = a0; t.a1 = a1; t.wd0 = wd0;
    t.rdy = rdy; t.ce = ce; t.swe = swe; t.saddr = saddr; t.ewd = ewd;
    t.rv = rv; t.re = re; t.rd0 = rd0; t.rd1 = rd1;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic cyc(input logic [1:0] v, input logic [1:0] we, input logic [1:0] rr,
                     input logic [4:0] a0, input logic [4:0] a1, input logic [63:0] wd0);
    @(negedge clk);
    req_valid = v; req_we = we; rsp_ready = rr;
    req_addr  = {a1, a0};
    req_wd    = {64'h1111_1111_1111_1111, wd0};
    #1;
  endtask

  localparam logic [63:0] DB = 64'hDEADBEEF_00000001;

  initial begin
    for (int k = 0; k < 32; k++) mem[k] = 64'h1000 + 64'(k);
    sram_rd = '0;
    reset = 1'b1; req_valid = '0; req_we = '0; rsp_ready = '0; req_addr = '0; req_wd = '0;

    // Reset state, with requests present to confirm grants are suppressed.
    @(negedge clk);
    req_valid = 2'b11;
    #1;
    chk("reset rsp_valid", 64'(rsp_valid), 0);
    chk("reset rsp_err",   64'(rsp_err), 0);
    chk("reset rsp_data0", rsp_data[63:0], 0);
    chk("reset req_ready", 64'(req_ready), 0);
    chk("reset sram_ce",   64'(sram_ce), 0);
    chk("reset sram_we",   64'(sram_we), 0);
    @(negedge clk);
    reset = 1'b0; req_valid = '0;

    //          v    we   rr   a0  a1 wd0      rdy  ce swe sa  ewd      rv   re   rd0          rd1
    // write then read addr 3 on requester 0
    tbl.push_back(mk(2'b01,2'b01,2'b11, 3, 0, DB,    2'b01,1,1, 3, DB,    2'b00,2'b00,0,0));
    tbl.push_back(mk(2'b01,2'b00,2'b11, 3, 0, 0,     2'b01,1,0, 3, 0,     2'b00,2'b00,0,0));
    tbl.push_back(mk(2'b00,2'b00,2'b11, 0, 0, 0,     2'b00,0,0, 0, 0,     2'b00,2'b00,0,0));
    tbl.push_back(mk(2'b00,2'b00,2'b11, 0, 0, 0,     2'b00,0,0, 0, 0,     2'b01,2'b00,DB,0));
    // both requesters reading continuously: pointer is at 1 here
    tbl.push_back(mk(2'b11,2'b00,2'b11, 1, 2, 0,     2'b10,1,0, 2, 0,     2'b00,2'b00,0,0));
    tbl.push_back(mk(2'b11,2'b00,2'b11, 1, 2, 0,     2'b01,1,0, 1, 0,     2'b00,2'b00,0,0));
    tbl.push_back(mk(2'b11,2'b00,2'b11, 1, 2, 0,     2'b10,1,0, 2, 0,     2'b10,2'b00,0,64'h1002));
    tbl.push_back(mk(2'b11,2'b00,2'b11, 1, 2, 0,     2'b01,1,0, 1, 0,     2'b01,2'b00,64'h1001,0));
    tbl.push_back(mk(2'b11,2'b00,2'b11, 1, 2, 0,     2'b10,1,0, 2, 0,     2'b10,2'b00,0,64'h1002));
    tbl.push_back(mk(2'b00,2'b00,2'b11, 0, 0, 0,     2'b00,0,0, 0, 0,     2'b01,2'b00,64'h1001,0));
    tbl.push_back(mk(2'b00,2'b00,2'b11, 0, 0, 0,     2'b00,0,0, 0, 0,     2'b10,2'b00,0,64'h1002));
    tbl.push_back(mk(2'b00,2'b00,2'b11, 0, 0, 0,     2'b00,0,0, 0, 0,     2'b00,2'b00,0,0));
    // out-of-range write to 17 and read from 20
    tbl.push_back(mk(2'b01,2'b01,2'b11,17, 0, 64'hBAD, 2'b01,0,0, 0, 0,   2'b00,2'b00,0,0));
    tbl.push_back(mk(2'b01,2'b00,2'b11,20, 0, 0,     2'b01,0,0, 0, 0,     2'b00,2'b00,0,0));
    tbl.push_back(mk(2'b00,2'b00,2'b11, 0, 0, 0,     2'b00,0,0, 0, 0,     2'b00,2'b00,0,0));
    tbl.push_back(mk(2'b00,2'b00,2'b11, 0, 0, 0,     2'b00,0,0, 0, 0,     2'b01,2'b01,0,0));
    // write 0xA to addr 0, read it back the next cycle
    tbl.push_back(mk(2'b01,2'b01,2'b11, 0, 0, 64'hA, 2'b01,1,1, 0, 64'hA, 2'b00,2'b00,0,0));
    tbl.push_back(mk(2'b01,2'b00,2'b11, 0, 0, 0,     2'b01,1,0, 0, 0,     2'b00,2'b00,0,0));
    tbl.push_back(mk(2'b00,2'b00,2'b11, 0, 0, 0,     2'b00,0,0, 0, 0,     2'b00,2'b00,0,0));
    tbl.push_back(mk(2'b00,2'b00,2'b11, 0, 0, 0,     2'b00,0,0, 0, 0,     2'b01,2'b00,64'hA,0));
    tbl.push_back(mk(2'b00,2'b00,2'b11, 0, 0, 0,     2'b00,0,0, 0, 0,     2'b00,2'b00,0,0));

    foreach (tbl[k]) begin
      cyc(tbl[k].v, tbl[k].we, tbl[k].rr, tbl[k].a0, tbl[k].a1, tbl[k].wd0);
      chk($sformatf("vec%0d req_ready", k), 64'(req_ready), 64'(tbl[k].rdy));
      chk($sformatf("vec%0d sram_ce", k),   64'(sram_ce),   64'(tbl[k].ce));
      chk($sformatf("vec%0d sram_we", k),   64'(sram_we),   64'(tbl[k].swe));
      if (tbl[k].ce)  chk($sformatf("vec%0d sram_addr", k), 64'(sram_addr), 64'(tbl[k].saddr));
      if (tbl[k].swe) chk($sformatf("vec%0d sram_wd", k), sram_wd, tbl[k].ewd);
      chk($sformatf("vec%0d rsp_valid", k), 64'(rsp_valid), 64'(tbl[k].rv));
      if (tbl[k].rv[0]) begin
        chk($sformatf("vec%0d rsp_data0", k), rsp_data[63:0], tbl[k].rd0);
        chk($sformatf("vec%0d rsp_err0", k), 64'(rsp_err[0]), 64'(tbl[k].re[0]));
      end
      if (tbl[k].rv[1]) begin
        chk($sformatf("vec%0d rsp_data1", k), rsp_data[127:64], tbl[k].rd1);
        chk($sformatf("vec%0d rsp_err1", k), 64'(rsp_err[1]), 64'(tbl[k].re[1]));
      end
    end

    // Held response on requester 1 blocks its next read until consumed (pointer at 1).
    cyc(2'b10, 2'b00, 2'b00, 0, 5, 0);
    chk("bp first grant", 64'(req_ready), 64'(2'b10));
    cyc(2'b10, 2'b00, 2'b00, 0, 6, 0);
    chk("bp in flight ready", 64'(req_ready), 0);
    chk("bp in flight valid", 64'(rsp_valid), 0);
    for (int k = 0; k < 4; k++) begin
      cyc(2'b10, 2'b00, 2'b00, 0, 6, 0);
      chk($sformatf("bp hold%0d ready", k), 64'(req_ready), 0);
      chk($sformatf("bp hold%0d valid", k), 64'(rsp_valid), 64'(2'b10));
      chk($sformatf("bp hold%0d data", k), rsp_data[127:64], 64'h1005);
    end
    cyc(2'b10, 2'b00, 2'b10, 0, 6, 0);
    chk("bp pop grant", 64'(req_ready), 64'(2'b10));
    chk("bp pop addr", 64'(sram_addr), 6);
    chk("bp pop data", rsp_data[127:64], 64'h1005);
    cyc(2'b00, 2'b00, 2'b00, 0, 0, 0);
    chk("bp gap valid", 64'(rsp_valid), 0);
    cyc(2'b00, 2'b00, 2'b10, 0, 0, 0);
    chk("bp second valid", 64'(rsp_valid), 64'(2'b10));
    chk("bp second data", rsp_data[127:64], 64'h1006);

    // Reset right after a read grant: response is dropped, pointer returns to 0.
    cyc(2'b01, 2'b00, 2'b11, 7, 0, 0);
    chk("rst grant before", 64'(req_ready), 64'(2'b01));
    @(negedge clk);
    reset = 1'b1; req_valid = 2'b11;
    #1;
    chk("rst mid ready", 64'(req_ready), 0);
    chk("rst mid ce", 64'(sram_ce), 0);
    chk("rst mid valid", 64'(rsp_valid), 0);
    @(negedge clk);
    reset = 1'b0; req_valid = '0;
    for (int k = 0; k < 3; k++) begin
      cyc(2'b00, 2'b00, 2'b11, 0, 0, 0);
      chk($sformatf("rst after%0d valid", k), 64'(rsp_valid), 0);
    end
    cyc(2'b11, 2'b00, 2'b11, 1, 2, 0);
    chk("rst first grant", 64'(req_ready), 64'(2'b01));
    cyc(2'b11, 2'b00, 2'b11, 1, 2, 0);
    chk("rst second grant", 64'(req_ready), 64'(2'b10));
    cyc(2'b00, 2'b00, 2'b11, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
